// File: rtl/alu_ctl_pkg.sv
// alu_ctl_pkg: shared definitions for the bit-serial ALU controller and its bench.
//   ALU_WIDTH_DEFAULT : default operand/result width
//   OP_*              : 4-bit operation codes {Ainvert, Binvert, op[1:0]}
//   state_t           : controller FSM state encoding
//   is_legal_op()     : 1 when a code is one of the seven supported operations
//   is_arith_op()     : 1 for ADD/SUB, the only ops that report carry/overflow
package alu_ctl_pkg;

  localparam int ALU_WIDTH_DEFAULT = 8;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] ctl);
    logic legal;
    case (ctl)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND: legal = 1'b1;
      default:                                               legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic is_arith_op(input logic [3:0] ctl);
    logic arith;
    case (ctl)
      OP_ADD, OP_SUB: arith = 1'b1;
      default:        arith = 1'b0;
    endcase
    return arith;
  endfunction

endpackage

// File: rtl/ALU_1bit.sv
// ALU_1bit: combinational 1-bit ALU slice (AND / OR / ADD / LESS select).
//   i_a, i_b             : operand bits
//   i_ainvert, i_binvert : invert operand before use
//   i_cin                : carry in
//   i_less               : value passed through when op = 11 (SLT)
//   i_op                 : 00 AND, 01 OR, 10 ADD, 11 LESS
//   o_result             : selected result bit
//   o_cout               : adder carry out
//   o_set                : adder sum bit (sign bit when used as the MSB slice)
//   o_overflow           : signed overflow, meaningful only on the MSB slice
module ALU_1bit (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_ainvert,
  input  logic       i_binvert,
  input  logic       i_cin,
  input  logic       i_less,
  input  logic [1:0] i_op,
  output logic       o_result,
  output logic       o_cout,
  output logic       o_set,
  output logic       o_overflow
);

  logic w_aa;
  logic w_bb;
  logic w_sum;

  assign w_aa       = i_a ^ i_ainvert;
  assign w_bb       = i_b ^ i_binvert;
  assign w_sum      = w_aa ^ w_bb ^ i_cin;
  assign o_cout     = (w_aa & w_bb) | (w_aa & i_cin) | (w_bb & i_cin);
  assign o_set      = w_sum;
  assign o_overflow = i_cin ^ o_cout;

  // Result multiplexer selected by the low two op bits.
  always_comb begin
    o_result = 1'b0;
    case (i_op)
      2'b00:   o_result = w_aa & w_bb;
      2'b01:   o_result = w_aa | w_bb;
      2'b10:   o_result = w_sum;
      2'b11:   o_result = i_less;
      default: o_result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: WIDTH-bit ALU evaluated LSB first, one bit per clock,
// through a single ALU_1bit slice.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, alu_ctl, a, b     : request and operands, sampled in IDLE/DONE
//   busy                     : high while bits are being processed
//   done                     : one-cycle pulse when result is updated
//   result, zero             : result and result==0, held between operations
//   overflow, c_out          : MSB-slice signed overflow / carry, ADD/SUB only
module alu_serial_ctrl
  import alu_ctl_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             c_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [3:0]       r_ctl;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;

  logic             w_slice_res;
  logic             w_slice_cout;
  logic             w_slice_set;
  logic             w_slice_ovf;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_final;
  logic             w_ovf_final;
  logic             w_cout_final;

  // Less input is tied low: SLT fixes up bit 0 at the final edge instead,
  // since the sign of a-b is only known once the MSB slice has run.
  ALU_1bit u_slice (
    .i_a        (r_a_sh[0]),
    .i_b        (r_b_sh[0]),
    .i_ainvert  (r_ctl[3]),
    .i_binvert  (r_ctl[2]),
    .i_cin      (r_carry),
    .i_less     (1'b0),
    .i_op       (r_ctl[1:0]),
    .o_result   (w_slice_res),
    .o_cout     (w_slice_cout),
    .o_set      (w_slice_set),
    .o_overflow (w_slice_ovf)
  );

  // New slice bit enters at the top, so after WIDTH shifts bit 0 is the LSB.
  assign w_res_next = {w_slice_res, r_res_sh[WIDTH-1:1]};

  // Final result and flags, valid while the MSB slice is being processed.
  always_comb begin
    w_final      = w_res_next;
    w_ovf_final  = 1'b0;
    w_cout_final = 1'b0;
    if (!is_legal_op(r_ctl)) begin
      w_final = '0;
    end else if (r_ctl == OP_SLT) begin
      w_final = {{(WIDTH-1){1'b0}}, w_slice_set};
    end else if (is_arith_op(r_ctl)) begin
      w_ovf_final  = w_slice_ovf;
      w_cout_final = w_slice_cout;
    end else begin
      w_final = w_res_next;
    end
  end

  // Controller FSM with operand/result shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_ctl    <= 4'b0000;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      c_out    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_state  <= ST_RUN;
            r_ctl    <= alu_ctl;
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res_sh <= '0;
            r_cnt    <= '0;
            // Binvert doubles as the +1 of two's-complement subtraction.
            r_carry  <= alu_ctl[2];
            busy     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_res_sh <= w_res_next;
          r_carry  <= w_slice_cout;
          if (r_cnt == LAST_BIT) begin
            r_state  <= ST_DONE;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= w_final;
            zero     <= (w_final == '0);
            overflow <= w_ovf_final;
            c_out    <= w_cout_final;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only when state is IDLE or DONE.
REQ-005 alu_ctl  input  4  operation code {Ainvert, Binvert, op}, sampled with start.
REQ-006 a  input  WIDTH  operand A, sampled with start.
REQ-007 b  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while an operation is in RUN.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 result  output  WIDTH  operation result, held until the next accepted start.
REQ-011 zero  output  1  result == 0, held with result.
REQ-012 overflow  output  1  signed overflow of ADD/SUB, 0 for other ops.
REQ-013 c_out  output  1  carry out of MSB for ADD/SUB, 0 for other ops.

Function
REQ-014 The block SHALL compute an N-bit operation bit-serially through one 1-bit ALU slice, LSB first, one bit per cycle.
REQ-015 Legal codes SHALL be: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1101 NAND, 1100 NOR, 0111 SLT; any other code is illegal.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after bit WIDTH-1, DONE->RUN on start else DONE->IDLE.
REQ-017 On accepted start at edge T, a, b, alu_ctl SHALL be latched, the bit counter cleared, the carry register loaded with Binvert, and busy SHALL rise after edge T.
REQ-018 Bit k SHALL be processed at edge T+1+k; done SHALL be high exactly during the cycle following edge T+WIDTH; busy SHALL be low in that cycle.
REQ-019 Carry out of slice k SHALL be registered as carry in of slice k+1.
REQ-020 The slice less input SHALL be 0 for every bit; for SLT, at the final edge result[0] SHALL be overwritten with the MSB slice set output and result[WIDTH-1:1] SHALL be 0.
REQ-021 overflow and c_out SHALL be captured from the MSB slice at the final edge for ADD/SUB and forced to 0 otherwise.
REQ-022 Illegal code SHALL run the full WIDTH cycles and complete with result=0, zero=1, overflow=0, c_out=0.
REQ-023 start while in RUN SHALL be ignored with no effect on the running operation.
REQ-024 start during DONE SHALL be accepted back-to-back; done stays a single-cycle pulse and busy rises after that edge.
REQ-025 result, zero, overflow, c_out SHALL change only at the final edge of an operation or on reset.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, carry 0, busy=0, done=0, result=0, zero=1, overflow=0, c_out=0, immediately and regardless of clock.
REQ-027 rst asserted mid-RUN SHALL abandon the operation with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-028 Op codes, state encodings and WIDTH default SHALL live in shared package alu_ctl_pkg, used by this block and its bench.
REQ-029 The design SHALL instantiate exactly one existing 1-bit slice ALU_1bit as its sole sub-module; all sequencing, shift registers and counter are local.

Verification (WIDTH=8)
REQ-030 ADD a=0x7F b=0x01, start at edge T -> done in cycle after T+8, result=0x80, overflow=1, c_out=0, zero=0.
REQ-031 SUB a=0x05 b=0x05 -> result=0x00, zero=1, c_out=1, overflow=0.
REQ-032 SLT a=0xFE b=0x01 -> result=0x01; SLT a=0x01 b=0xFE -> result=0x00.
REQ-033 NOR a=0xF0 b=0x0F -> 0x00 zero=1; NAND a=0xFF b=0x0F -> 0xF0; code 1010 -> result=0x00, done still pulses.
REQ-034 start pulsed at T+3 during RUN -> ignored, result unchanged; start during DONE -> second result correct with done at T+18.
REQ-035 rst at T+4 mid-ADD -> outputs at reset values asynchronously, no done; next ADD 0x01+0x02 -> 0x03.
